// File: rtl/i2c_target_rx.sv
// I2C target endpoint: oversampled SCL/SDA, START/STOP detection, 7-bit address
// match, write-byte reception and read-byte service through an open-drain SDA enable.
module i2c_target_rx #(
  parameter logic [6:0]  ADDR     = 7'h42,
  parameter int unsigned SYNC_LEN = 2
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
  } state_e;

  logic [SYNC_LEN-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic                scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        rw_q, rw_d;
  logic        phase_q, phase_d;
  logic        done_q, done_d;
  logic        ack_q, ack_d;
  logic        sda_oe_q, sda_oe_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        tx_req_q, tx_req_d;
  logic        busy_q, busy_d;
  logic        stop_det_q, stop_det_d;

  logic scl_s, sda_s, scl_rise, scl_fall, scl_high, start_ev, stop_ev;
  logic [7:0] shift_in;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_LEN-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_LEN-2:0], sda_in};
    scl_hist_d = scl_sync_q[SYNC_LEN-1];
    sda_hist_d = sda_sync_q[SYNC_LEN-1];
  end

  assign scl_s    = scl_sync_q[SYNC_LEN-1];
  assign sda_s    = sda_sync_q[SYNC_LEN-1];
  assign scl_rise = scl_s & ~scl_hist_q;
  assign scl_fall = ~scl_s & scl_hist_q;
  assign scl_high = scl_s & scl_hist_q;
  assign start_ev = scl_high & sda_hist_q & ~sda_s;
  assign stop_ev  = scl_high & ~sda_hist_q & sda_s;
  assign shift_in = {shift_q[6:0], sda_s};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    phase_d    = phase_q;
    done_d     = done_q;
    ack_d      = ack_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;
    stop_det_d = 1'b0;

    if (stop_ev) begin
      state_d    = S_IDLE;
      bit_cnt_d  = '0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      stop_det_d = 1'b1;
      phase_d    = 1'b0;
      done_d     = 1'b0;
    end else if (start_ev) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      phase_d   = 1'b0;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ADDR: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (shift_in[7:1] == ADDR) begin
                busy_d  = 1'b1;
                rw_d    = shift_in[0];
                phase_d = 1'b0;
                state_d = S_ADDR_ACK;
              end else begin
                busy_d  = 1'b0;
                state_d = S_WAIT_STOP;
              end
            end
          end
        end
        // phase_q: 0 = before the ACK bit is driven, 1 = ACK bit on the bus
        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else if (rw_q) begin
              shift_d  = tx_data;
              sda_oe_d = ~tx_data[7];
              phase_d  = 1'b1;
              done_d   = 1'b0;
              state_d  = S_RD_DATA;
            end else begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              state_d  = S_WR_DATA;
            end
          end else if (scl_rise && phase_q && rw_q) begin
            tx_req_d = 1'b1;
          end
        end
        S_WR_DATA: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = shift_in;
              rx_valid_d = 1'b1;
              ack_d      = rx_ready;
              phase_d    = 1'b0;
              state_d    = S_WR_ACK;
            end
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = ack_q;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              state_d  = ack_q ? S_WR_DATA : S_WAIT_STOP;
            end
          end
        end
        // phase_q: byte loaded from tx_data; done_q: 8th bit clocked out
        S_RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) done_d = 1'b1;
          end else if (scl_fall) begin
            if (!phase_q) begin
              shift_d  = tx_data;
              sda_oe_d = ~tx_data[7];
              phase_d  = 1'b1;
            end else if (done_q) begin
              sda_oe_d = 1'b0;
              done_d   = 1'b0;
              phase_d  = 1'b0;
              state_d  = S_RD_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              tx_req_d = 1'b1;
              phase_d  = 1'b0;
              state_d  = S_RD_DATA;
            end else begin
              state_d = S_WAIT_STOP;
            end
          end
        end
        S_WAIT_STOP: sda_oe_d = 1'b0;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rw_q       <= 1'b0;
      phase_q    <= 1'b0;
      done_q     <= 1'b0;
      ack_q      <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      stop_det_q <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      phase_q    <= phase_d;
      done_q     <= done_d;
      ack_q      <= ack_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
      stop_det_q <= stop_det_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;
  assign stop_det = stop_det_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: bit-level I2C controller model, transaction-level
// reference model feeding expectation queues, and monitors that consume them.
module tb_i2c_target_rx;

  localparam logic [6:0] OWN = 7'h42;
  localparam int Q = 4;

  typedef struct packed {
    logic oe;
    logic busy;
  } samp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_drv = 1'b1;
  logic       sda_ctrl = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       sda_bus;
  logic       sda_oe, rx_valid, tx_req, busy, stop_det;
  logic [7:0] rx_data;

  samp_t      exp_samp[$];
  logic [7:0] exp_rx[$];
  int         exp_tx[$];
  int         exp_stop[$];
  int         errors = 0;
  int         checks = 0;

  logic [7:0] wbytes[4];
  logic [7:0] rbytes[4];
  bit         wready[4];

  event sample_ev;

  assign sda_bus = sda_ctrl & ~sda_oe;

  i2c_target_rx #(.ADDR(OWN), .SYNC_LEN(2)) dut (
    .clk_in(clk), .rst_n(rst_n), .scl_in(scl_drv), .sda_in(sda_bus),
    .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_req(tx_req), .busy(busy), .stop_det(stop_det)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_samp(input logic oe, input logic bsy);
    samp_t s;
    s.oe = oe;
    s.busy = bsy;
    exp_samp.push_back(s);
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic v, input bit samp);
    wait_q(); sda_ctrl = v;
    wait_q(); scl_drv = 1'b1;
    wait_q(); if (samp) -> sample_ev;
    wait_q(); scl_drv = 1'b0;
  endtask

  task automatic start_cond();
    if (scl_drv == 1'b0) begin
      wait_q(); sda_ctrl = 1'b1;
      wait_q(); scl_drv = 1'b1;
    end
    wait_q(); sda_ctrl = 1'b0;
    wait_q(); scl_drv = 1'b0;
  endtask

  task automatic stop_cond();
    wait_q(); sda_ctrl = 1'b0;
    wait_q(); scl_drv = 1'b1;
    wait_q(); sda_ctrl = 1'b1;
    wait_q(); wait_q();
  endtask

  // Reference model: what the controller should see on every ACK / read bit,
  // which bytes get delivered, how many tx_req and stop_det pulses occur.
  task automatic model_txn(input logic [6:0] a, input bit rw, input int n, input bit do_stop);
    bit match = (a == OWN);
    bit accepting = 1'b1;
    push_samp(match, match);
    if (match && rw) begin
      exp_tx.push_back(1);
      for (int i = 0; i < n; i++) begin
        for (int b = 7; b >= 0; b--) push_samp(~rbytes[i][b], 1'b1);
        push_samp(1'b0, 1'b1);
        if (i < n - 1) exp_tx.push_back(1);
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        if (match && accepting) begin
          exp_rx.push_back(wbytes[i]);
          push_samp(wready[i], 1'b1);
          accepting = wready[i];
        end else begin
          push_samp(1'b0, match);
        end
      end
    end
    if (do_stop) exp_stop.push_back(1);
  endtask

  task automatic txn(input logic [6:0] a, input bit rw, input int n, input bit do_stop);
    logic [7:0] abyte;
    bit match = (a == OWN);
    abyte = {a, rw};
    model_txn(a, rw, n, do_stop);
    if (rw) tx_data = rbytes[0];
    start_cond();
    for (int b = 7; b >= 0; b--) bit_xfer(abyte[b], 1'b0);
    bit_xfer(1'b1, 1'b1);
    for (int i = 0; i < n; i++) begin
      if (match && rw) begin
        for (int b = 7; b >= 0; b--) bit_xfer(1'b1, 1'b1);
        if (i + 1 < n) tx_data = rbytes[i+1];
        bit_xfer(i == n - 1, 1'b1);
      end else begin
        rx_ready = wready[i];
        for (int b = 7; b >= 0; b--) bit_xfer(wbytes[i][b], 1'b0);
        bit_xfer(1'b1, 1'b1);
      end
    end
    if (do_stop) stop_cond();
  endtask

  initial begin : sample_monitor
    samp_t e;
    forever begin
      @(sample_ev);
      chk("sample_expected", exp_samp.size() != 0, 1);
      if (exp_samp.size() != 0) begin
        e = exp_samp.pop_front();
        chk("sda_oe", sda_oe, e.oe);
        chk("busy", busy, e.busy);
      end
    end
  end

  initial begin : pulse_monitor
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        chk("rx_valid_expected", exp_rx.size() != 0, 1);
        if (exp_rx.size() != 0) chk("rx_data", rx_data, exp_rx.pop_front());
        chk("rx_tx_overlap", tx_req, 0);
      end
      if (tx_req) begin
        chk("tx_req_expected", exp_tx.size() != 0, 1);
        if (exp_tx.size() != 0) void'(exp_tx.pop_front());
      end
      if (stop_det) begin
        chk("stop_det_expected", exp_stop.size() != 0, 1);
        if (exp_stop.size() != 0) void'(exp_stop.pop_front());
        chk("busy_at_stop", busy, 0);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int waited;
    repeat (5) @(negedge clk);
    chk("reset_sda_oe", sda_oe, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_tx_req", tx_req, 0);
    chk("reset_busy", busy, 0);
    chk("reset_stop_det", stop_det, 0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    wbytes[0] = 8'hA5; wready[0] = 1'b1;
    txn(OWN, 1'b0, 1, 1'b1);
    wbytes[0] = 8'h11; wbytes[1] = 8'h22; wready[0] = 1'b1; wready[1] = 1'b1;
    txn(7'h46, 1'b0, 2, 1'b1);
    rbytes[0] = 8'h3C; rbytes[1] = 8'hC3;
    txn(OWN, 1'b1, 2, 1'b1);
    wbytes[0] = 8'h5A; wbytes[1] = 8'h77; wready[0] = 1'b0; wready[1] = 1'b1;
    txn(OWN, 1'b0, 2, 1'b1);
    wbytes[0] = 8'h01; wready[0] = 1'b1;
    txn(OWN, 1'b0, 1, 1'b0);
    rbytes[0] = 8'h96;
    txn(OWN, 1'b1, 1, 1'b1);

    for (int k = 0; k < 16; k++) begin
      logic [6:0] a;
      bit rw, do_stop;
      int n;
      a = ($urandom_range(0, 2) != 0) ? OWN : 7'($urandom);
      rw = 1'($urandom);
      n = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) begin
        wbytes[i] = 8'($urandom);
        rbytes[i] = 8'($urandom);
        wready[i] = ($urandom_range(0, 3) != 0);
      end
      do_stop = (k == 15) || ($urandom_range(0, 2) != 0);
      txn(a, rw, n, do_stop);
    end

    // Reset while the target is driving the first read bit low
    tx_data = 8'h00;
    push_samp(1'b1, 1'b1);
    exp_tx.push_back(1);
    start_cond();
    for (int b = 7; b >= 0; b--) bit_xfer((b == 0) || (b == 2) || (b == 7), 1'b0);
    bit_xfer(1'b1, 1'b1);
    waited = 0;
    while (sda_oe !== 1'b1 && waited < 12) begin
      @(negedge clk);
      waited++;
    end
    chk("t6_driving_before_reset", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_sda_oe", sda_oe, 0);
    chk("t6_rx_data", rx_data, 0);
    chk("t6_rx_valid", rx_valid, 0);
    chk("t6_tx_req", tx_req, 0);
    chk("t6_busy", busy, 0);
    chk("t6_stop_det", stop_det, 0);
    scl_drv = 1'b1;
    sda_ctrl = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    wbytes[0] = 8'h9E; wready[0] = 1'b1;
    txn(OWN, 1'b0, 1, 1'b1);

    repeat (20) @(negedge clk);
    chk("samp_queue_drained", exp_samp.size(), 0);
    chk("rx_queue_drained", exp_rx.size(), 0);
    chk("tx_queue_drained", exp_tx.size(), 0);
    chk("stop_queue_drained", exp_stop.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
